// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream_ser serializer.
// Build macro PISO_PARITY_EN appends one even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef PISO_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Parity helper operates on a zero-extended word; DATA_W must not exceed this.
  localparam int unsigned PARITY_MAX_W = 64;

  function automatic int unsigned cnt_width(input int unsigned nbits);
    return (nbits < 2) ? 1 : $clog2(nbits);
  endfunction

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Modulo-NBITS bit position counter with first/last position flags.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int unsigned NBITS = 8,
  parameter int unsigned CNT_W = cnt_width(NBITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             is_first_o,
  output logic             is_last_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority; the only wrap is from LAST back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign is_first_o = (cnt_q == '0);
  assign is_last_o  = (cnt_q == LAST);

endmodule

// File: rtl/piso_stream_ser.sv
// Parallel-in/serial-out converter with valid/ready on both sides and frame markers.
// Defining PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_stream_ser
  import piso_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ser_ready,
  output logic              ser_valid,
  output logic              ser_data,
  output logic              ser_first,
  output logic              ser_last,
  output logic              busy
);

  localparam int unsigned NBITS = DATA_W + PARITY_BITS;
  localparam int unsigned CNT_W = cnt_width(NBITS);

  state_e           state_q, state_d;
  logic [NBITS-1:0] sr_q, sr_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_first_q, ser_first_d;
  logic             ser_last_q, ser_last_d;
  logic             busy_q, busy_d;

  logic             beat;
  logic             load;
  logic [NBITS-1:0] load_word;
  logic [NBITS-1:0] sr_shift;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_is_first;
  logic             cnt_is_last;

  function automatic logic head(input logic [NBITS-1:0] w);
    return MSB_FIRST ? w[NBITS-1] : w[0];
  endfunction

  // Parity sits in the slot shifted out last for the chosen bit order.
`ifdef PISO_PARITY_EN
  logic par_bit;
  assign par_bit   = even_parity(PARITY_MAX_W'(in_data));
  assign load_word = MSB_FIRST ? {in_data, par_bit} : {par_bit, in_data};
`else
  assign load_word = in_data;
`endif

  assign beat     = ser_valid_q & ser_ready;
  assign in_ready = rst_n & ((state_q == IDLE) | (ser_last_q & ser_ready));
  assign load     = in_valid & in_ready;

  piso_bit_cnt #(
    .NBITS (NBITS),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (load),
    .inc_i      (beat & ~load),
    .cnt_o      (cnt_q),
    .is_first_o (cnt_is_first),
    .is_last_o  (cnt_is_last)
  );

  // Next state and registered-output values; everything holds when there is no beat.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    ser_data_d  = ser_data_q;
    ser_first_d = (state_q == SHIFT) && cnt_is_first;
    ser_last_d  = ser_last_q;
    sr_shift    = MSB_FIRST ? {sr_q[NBITS-2:0], 1'b0} : {1'b0, sr_q[NBITS-1:1]};

    unique case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (beat && cnt_is_last) state_d = load ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      sr_d        = load_word;
      ser_data_d  = head(load_word);
      ser_first_d = 1'b1;
      ser_last_d  = 1'b0;
    end else if (beat) begin
      sr_d        = sr_shift;
      ser_first_d = 1'b0;
      if (cnt_is_last) begin
        ser_data_d = IDLE_LEVEL;
        ser_last_d = 1'b0;
      end else begin
        ser_data_d = head(sr_shift);
        ser_last_d = (cnt_q == CNT_W'(NBITS - 2));
      end
    end

    ser_valid_d = (state_d == SHIFT);
    busy_d      = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      ser_valid_q <= 1'b0;
      ser_data_q  <= IDLE_LEVEL;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      ser_valid_q <= ser_valid_d;
      ser_data_q  <= ser_data_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
    end
  end

  assign ser_valid = ser_valid_q;
  assign ser_data  = ser_data_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_piso_stream_ser.sv
// Self-checking bench for piso_stream_ser: MSB-first and LSB-first instances, scoreboard of expected bits.
module tb_piso_stream_ser;

`ifdef PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef struct packed {
    logic d;
    logic f;
    logic l;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       ser_ready;
  logic       in_valid, in_valid_l;
  logic [7:0] in_data, in_data_l;
  logic       in_ready, ser_valid, ser_data, ser_first, ser_last, busy;
  logic       in_ready_l, ser_valid_l, ser_data_l, ser_first_l, ser_last_l, busy_l;

  exp_t exp_m[$];
  exp_t exp_l[$];
  int   n_vec = 0;
  int   n_err = 0;

  piso_stream_ser #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ser_ready(ser_ready), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_first(ser_first), .ser_last(ser_last), .busy(busy)
  );

  piso_stream_ser #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_l), .in_ready(in_ready_l), .in_data(in_data_l),
    .ser_ready(ser_ready), .ser_valid(ser_valid_l), .ser_data(ser_data_l),
    .ser_first(ser_first_l), .ser_last(ser_last_l), .busy(busy_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference frame model: data bits in the selected order, then even parity if built.
  function automatic void push_word(input bit msb, input logic [7:0] w);
    exp_t e;
    logic b;
    for (int i = 0; i < NB; i++) begin
      if (i < 8) b = msb ? w[7-i] : w[i];
      else       b = ^w;
      e.d = b;
      e.f = (i == 0);
      e.l = (i == NB - 1);
      if (msb) exp_m.push_back(e);
      else     exp_l.push_back(e);
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ser_ready = 1'b1;
    in_valid = 1'b0; in_data = '0; in_valid_l = 1'b0; in_data_l = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if ({ser_valid, ser_first, ser_last, busy, ser_data} !== 5'b0) begin
      n_err++; $display("FAIL reset_outs got %b want 00000", {ser_valid, ser_first, ser_last, busy, ser_data});
    end
    n_vec++; if ({ser_valid_l, ser_first_l, ser_last_l, busy_l, ser_data_l} !== 5'b0) begin
      n_err++; $display("FAIL reset_outs_lsb got %b want 00000", {ser_valid_l, ser_first_l, ser_last_l, busy_l, ser_data_l});
    end
    n_vec++; if ({in_ready, in_ready_l} !== 2'b00) begin
      n_err++; $display("FAIL reset_in_ready got %b want 00", {in_ready, in_ready_l});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if ({in_ready, in_ready_l, ser_valid} !== 3'b110) begin
      n_err++; $display("FAIL post_reset got %b want 110", {in_ready, in_ready_l, ser_valid});
    end
  endtask

  task automatic test_single();
    exp_t e;
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'hA5; push_word(1'b1, 8'hA5);
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_accept in_ready got %b want 1", in_ready); end
    for (int c = 1; c <= NB; c++) begin
      @(posedge clk); #1 in_valid = 1'b0; in_data = 8'($urandom);
      @(negedge clk);
      e = exp_m.pop_front();
      n_vec++; if ({ser_valid, busy, ser_data, ser_first, ser_last} !== {2'b11, e.d, e.f, e.l}) begin
        n_err++; $display("FAIL single_bit cycle %0d got v/b/d/f/l %b want %b", c,
                          {ser_valid, busy, ser_data, ser_first, ser_last}, {2'b11, e.d, e.f, e.l});
      end
      n_vec++; if (in_ready !== (c == NB)) begin
        n_err++; $display("FAIL single_in_ready cycle %0d got %b want %b", c, in_ready, (c == NB));
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if ({ser_valid, in_ready, busy, ser_data} !== 4'b0100) begin
      n_err++; $display("FAIL single_end got v/r/b/d %b want 0100", {ser_valid, in_ready, busy, ser_data});
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'hA5; push_word(1'b1, 8'hA5);
    for (int c = 1; c <= 2 * NB; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin in_data = 8'h3C; push_word(1'b1, 8'h3C); end
      if (c == NB + 1) begin in_valid = 1'b0; in_data = 8'hFF; end
      @(negedge clk);
      e = exp_m.pop_front();
      n_vec++; if ({ser_valid, ser_data, ser_first, ser_last} !== {1'b1, e.d, e.f, e.l}) begin
        n_err++; $display("FAIL b2b_bit cycle %0d got v/d/f/l %b want %b", c,
                          {ser_valid, ser_data, ser_first, ser_last}, {1'b1, e.d, e.f, e.l});
      end
      n_vec++; if (in_ready !== (c == NB || c == 2 * NB)) begin
        n_err++; $display("FAIL b2b_in_ready cycle %0d got %b want %b", c, in_ready, (c == NB || c == 2 * NB));
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end ser_valid got %b want 0", ser_valid); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   c;
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'hA5; push_word(1'b1, 8'hA5);
    c = 0;
    while (exp_m.size() > 0 && c < 40) begin
      c++;
      @(posedge clk); #1 in_valid = 1'b0;
      ser_ready = !(c >= 5 && c <= 7);
      @(negedge clk);
      e = exp_m[0];
      n_vec++; if ({ser_valid, ser_data, ser_first, ser_last} !== {1'b1, e.d, e.f, e.l}) begin
        n_err++; $display("FAIL bp_bit cycle %0d got v/d/f/l %b want %b", c,
                          {ser_valid, ser_data, ser_first, ser_last}, {1'b1, e.d, e.f, e.l});
      end
      n_vec++; if (in_ready !== (e.l && ser_ready)) begin
        n_err++; $display("FAIL bp_in_ready cycle %0d got %b want %b", c, in_ready, (e.l && ser_ready));
      end
      if (ser_ready) void'(exp_m.pop_front());
    end
    n_vec++; if (c != NB + 3) begin n_err++; $display("FAIL bp_length got %0d cycles want %0d", c, NB + 3); end
    @(posedge clk); #1 ser_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL bp_end ser_valid got %b want 0", ser_valid); end
    exp_m.delete();
  endtask

  task automatic test_lsb_first();
    exp_t e;
    int   c;
    @(negedge clk);
    n_vec++; if ({ser_valid_l, ser_data_l} !== 2'b00) begin
      n_err++; $display("FAIL lsb_pre got v/d %b want 00", {ser_valid_l, ser_data_l});
    end
    @(posedge clk); #1 in_valid_l = 1'b1; in_data_l = 8'h01; push_word(1'b0, 8'h01);
    c = 0;
    while (exp_l.size() > 0 && c < 30) begin
      c++;
      @(posedge clk); #1 in_valid_l = 1'b0; in_data_l = 8'h80;
      @(negedge clk);
      e = exp_l.pop_front();
      n_vec++; if ({ser_valid_l, ser_data_l, ser_first_l, ser_last_l} !== {1'b1, e.d, e.f, e.l}) begin
        n_err++; $display("FAIL lsb_bit cycle %0d got v/d/f/l %b want %b", c,
                          {ser_valid_l, ser_data_l, ser_first_l, ser_last_l}, {1'b1, e.d, e.f, e.l});
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if ({ser_valid_l, ser_data_l, in_ready_l} !== 3'b001) begin
      n_err++; $display("FAIL lsb_post got v/d/r %b want 001", {ser_valid_l, ser_data_l, in_ready_l});
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_t e;
    int   c;
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'hFF; push_word(1'b1, 8'hFF);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1 in_valid = 1'b0;
      if (k == 3) begin rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hAA; end
      @(negedge clk);
      e = exp_m.pop_front();
      n_vec++; if ({ser_valid, ser_data} !== {1'b1, e.d}) begin
        n_err++; $display("FAIL rst_pre_bit %0d got v/d %b want %b", k, {ser_valid, ser_data}, {1'b1, e.d});
      end
    end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    exp_m.delete();
    @(posedge clk); #1 rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if ({ser_valid, busy, in_ready, ser_data} !== 4'b0010) begin
      n_err++; $display("FAIL rst_after got v/b/r/d %b want 0010", {ser_valid, busy, in_ready, ser_data});
    end
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h0F; push_word(1'b1, 8'h0F);
    c = 0;
    while (exp_m.size() > 0 && c < 30) begin
      c++;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      e = exp_m.pop_front();
      n_vec++; if ({ser_valid, ser_data, ser_first, ser_last} !== {1'b1, e.d, e.f, e.l}) begin
        n_err++; $display("FAIL rst_next_bit cycle %0d got v/d/f/l %b want %b", c,
                          {ser_valid, ser_data, ser_first, ser_last}, {1'b1, e.d, e.f, e.l});
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL rst_next_end ser_valid got %b want 0", ser_valid); end
  endtask

  // A5 then 07 back to back; in the parity build the trailing bits are 0 then 1.
  task automatic test_parity_frames();
    exp_t e;
    int   c;
    int   lasts;
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'hA5; push_word(1'b1, 8'hA5);
    c = 0; lasts = 0;
    while (exp_m.size() > 0 && c < 40) begin
      c++;
      @(posedge clk); #1;
      if (c == 1) begin in_data = 8'h07; push_word(1'b1, 8'h07); end
      if (c == NB + 1) in_valid = 1'b0;
      @(negedge clk);
      e = exp_m.pop_front();
      if (ser_last) lasts++;
      n_vec++; if ({ser_valid, ser_data, ser_first, ser_last} !== {1'b1, e.d, e.f, e.l}) begin
        n_err++; $display("FAIL par_bit cycle %0d got v/d/f/l %b want %b", c,
                          {ser_valid, ser_data, ser_first, ser_last}, {1'b1, e.d, e.f, e.l});
      end
    end
    n_vec++; if (c != 2 * NB || lasts != 2) begin
      n_err++; $display("FAIL par_frames got %0d cycles %0d lasts want %0d cycles 2 lasts", c, lasts, 2 * NB);
    end
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic test_random_stream();
    exp_t e;
    int   words_left;
    int   c;
    bit   acc;
    logic exp_rdy;
    words_left = 10; c = 0; acc = 1'b0;
    while ((words_left > 0 || exp_m.size() > 0) && c < 600) begin
      c++;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      acc = 1'b0;
      ser_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && words_left > 0 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1; in_data = 8'($urandom);
      end
      @(negedge clk);
      n_vec++; if (ser_valid !== (exp_m.size() > 0)) begin
        n_err++; $display("FAIL rnd_valid cycle %0d got %b want %b", c, ser_valid, (exp_m.size() > 0));
      end
      if (exp_m.size() > 0) begin
        e = exp_m[0];
        exp_rdy = e.l && ser_ready;
        n_vec++; if ({ser_data, ser_first, ser_last} !== {e.d, e.f, e.l}) begin
          n_err++; $display("FAIL rnd_bit cycle %0d got d/f/l %b want %b", c, {ser_data, ser_first, ser_last}, {e.d, e.f, e.l});
        end
        if (ser_ready) void'(exp_m.pop_front());
      end else begin
        exp_rdy = 1'b1;
        n_vec++; if (ser_data !== 1'b0) begin n_err++; $display("FAIL rnd_idle_level cycle %0d got %b want 0", c, ser_data); end
      end
      n_vec++; if (in_ready !== exp_rdy) begin
        n_err++; $display("FAIL rnd_in_ready cycle %0d got %b want %b", c, in_ready, exp_rdy);
      end
      if (in_valid && exp_rdy) begin
        push_word(1'b1, in_data);
        words_left--;
        acc = 1'b1;
      end
    end
    n_vec++; if (words_left != 0 || exp_m.size() != 0) begin
      n_err++; $display("FAIL rnd_timeout got %0d words left %0d bits pending want 0 0", words_left, exp_m.size());
    end
    @(posedge clk); #1 in_valid = 1'b0; ser_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_lsb_first();
    test_reset_mid_frame();
    test_parity_frames();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_stream_ser.md
Name: piso_stream_ser

Overview:
Parametrised parallel-in/serial-out converter with valid/ready handshakes on both sides. Accepts a DATA_W-bit word and emits it one bit per accepted serial beat, with the bit order selectable. Frame markers flag the first and last bit of each word. Back-to-back words stream with no idle cycle between them. Sits between a parallel datapath and a serial line driver, such as a bit-banged link or a test-pattern output.

Parameters:
DATA_W, 8, word width in bits; legal values are >= 2.
MSB_FIRST, 1, 1 = shift out bit DATA_W-1 first; 0 = shift out bit 0 first.
IDLE_LEVEL, 0, value driven on ser_data while ser_valid = 0.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  parallel word is valid.
in_ready  out  1  block can accept a word this cycle.
in_data  in  DATA_W  parallel word.
ser_ready  in  1  downstream consumes the current serial bit this cycle.
ser_valid  out  1  ser_data holds a valid bit.
ser_data  out  1  serial bit.
ser_first  out  1  current bit is the first bit of the frame.
ser_last  out  1  current bit is the last bit of the frame.
busy  out  1  a frame is in progress (state is SHIFT).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled only at the clk rising edge.
- Reset values:
  - state = IDLE, shift register = 0, bit count = 0.
  - ser_valid = 0, ser_first = 0, ser_last = 0, busy = 0, ser_data = IDLE_LEVEL.
  - in_ready is forced to 0 while rst_n = 0.
- Frame length: NBITS = DATA_W, or DATA_W+1 when the parity option is built.
- Bit counter: $clog2(NBITS) bits wide. Counts 0..NBITS-1 and returns to 0 on the last bit; no other wrap.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load the shift register, set count = 0, go to SHIFT.
  - Latency: the first bit appears on ser_data in the cycle after acceptance.
- State SHIFT:
  - ser_valid = 1.
  - ser_data = the current MSB of the shift register if MSB_FIRST = 1, else the current LSB.
  - ser_first = (count == 0). ser_last = (count == NBITS-1).
- Beat rule: a beat occurs on ser_valid & ser_ready.
  - On a beat, shift by one position and increment count.
  - With no beat, all outputs and state hold. ser_data must remain stable under backpressure.
- Last-bit beat:
  - in_ready = ser_last & ser_ready, combinational.
  - If in_valid is also high, load the new word and stay in SHIFT with count = 0. This gives zero-bubble streaming.
  - Otherwise go to IDLE.
- in_ready is 0 in SHIFT except on the last-bit beat.
- in_data is sampled only at the acceptance edge. Later changes to in_data have no effect.
- Reset mid-frame: the frame is dropped and not resumed. In the cycle after the reset edge, ser_valid = 0. With rst_n = 1, in_ready = 1 from that cycle on.
- If in_valid and a reset edge coincide, the reset wins and the word is not accepted.
- busy = (state == SHIFT).
- All outputs are driven from registers, except in_ready, which is combinational from state, ser_last and ser_ready.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined:
  - One even-parity bit (XOR of the DATA_W bits of the accepted word) is sent after the data bits.
  - The parity value is computed at acceptance.
  - ser_last marks the parity bit. NBITS = DATA_W+1.
- When undefined: no parity logic is built and NBITS = DATA_W.

Decomposition:
- Package piso_pkg:
  - State enum {IDLE, SHIFT} in 1-bit logic.
  - Function for counter width: clog2 of NBITS.
  - Helper function computing even parity of a DATA_W vector.
- Sub-module piso_bit_cnt:
  - Parametrised modulo-NBITS counter with inputs clr and inc, and outputs cnt, is_first and is_last.
  - Instantiated once.
- The shift register and FSM stay in the top module.

Test Plan:
1. Single word, MSB-first. DATA_W=8, MSB_FIRST=1, ser_ready=1, in_data=0xA5 accepted at cycle 0.
   -> ser_data = 1,0,1,0,0,1,0,1 on cycles 1-8; ser_first on cycle 1, ser_last on cycle 8; ser_valid = 0 and in_ready = 1 on cycle 9.
2. Back-to-back. 0xA5 then 0x3C, with in_valid held.
   -> 16 contiguous ser_valid cycles; 0x3C accepted on cycle 8 (in_ready = 1 only then); second frame bits 0,0,1,1,1,1,0,0.
3. Backpressure. Send 0xA5; drop ser_ready for 3 cycles while the 5th bit (0) is presented.
   -> ser_data stays 0 and count stays put for 3 cycles; frame completes 3 cycles late with the correct bit sequence.
4. LSB-first. MSB_FIRST=0, in_data=0x01.
   -> ser_data = 1,0,0,0,0,0,0,0; IDLE_LEVEL driven before and after the frame.
5. Reset mid-frame. rst_n=0 for 1 edge after bit 3 of 0xFF.
   -> next cycle ser_valid = 0, busy = 0; in_ready = 1 once rst_n = 1; next word 0x0F serialises fully with no residue from the old frame.
6. Parity build (PISO_PARITY_EN). Send 0xA5, then 0x07.
   -> 9-bit frames; parity bits 0 and 1 respectively; ser_last on the 9th bit of each frame.
